// File: rtl/vpu_mem_resp_if.sv
// -----------------------------------------------------------------------------
// vpu_mem_resp_if
// Bundle of every non-clock signal between the VPU/host side and the
// vpu_mem_resp operand memory.
//   master : VPU + host side (drives addresses, write data, strobes)
//   slave  : the memory (drives read data, ready/enable flags, err)
// Signals:
//   addr_a / addr_b    operand A / operand B (constant) read addresses
//   addr_c / data_c    result write address / data, strobed by done
//   data_a / data_b    read data for addr_a / addr_b
//   mem_rdy            memory accepting VPU traffic
//   mem_read_en        read port enabled
//   mem_write_en       write port enabled
//   host_we / host_addr / host_wdata   host preload write port
//   err                sticky out-of-range access flag
// -----------------------------------------------------------------------------
interface vpu_mem_resp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] data_c;
    logic              done;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              mem_rdy;
    logic              mem_read_en;
    logic              mem_write_en;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              err;

    modport master (
        output addr_a, addr_b, addr_c, data_c, done,
        output host_we, host_addr, host_wdata,
        input  data_a, data_b, mem_rdy, mem_read_en, mem_write_en, err
    );

    modport slave (
        input  addr_a, addr_b, addr_c, data_c, done,
        input  host_we, host_addr, host_wdata,
        output data_a, data_b, mem_rdy, mem_read_en, mem_write_en, err
    );
endinterface

// File: rtl/vpu_mem_resp.sv
// -----------------------------------------------------------------------------
// vpu_mem_resp
// Operand/result memory for the VPU: two pipelined read ports (A, B), one VPU
// result write port (C, strobed by done) and a host preload write port.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset; aborts in-flight reads and any
//         buffered host write, then restarts initialisation
//   bus   vpu_mem_resp_if.slave (see the interface file for the signal list)
//
// Parameters:
//   DATA_W  data word width
//   ADDR_W  VPU address width
//   DEPTH   number of stored words (addresses 0..DEPTH-1)
//   RD_LAT  read latency 1..3: the address sampled at edge t is visible on
//           data_a/data_b after edge t+RD_LAT-1
//
// Configuration macro:
//   VPU_MEM_ZERO_INIT_EN  defined: after reset the CLEAR state writes zero to
//                         every address (one per cycle) before READY, so
//                         mem_rdy rises DEPTH cycles after reset release.
//                         undefined: CLEAR lasts a single cycle, no clear
//                         counter exists and memory contents after reset are
//                         unspecified.
//
// Write arbitration in READY: the VPU write (done) always wins the write
// port. A host write in the same cycle is parked in a one-entry buffer and
// committed on the next cycle without done; it is dropped when it targets the
// VPU write address. A newer colliding host write replaces a parked one.
// Reads return the memory contents before the writes of the same edge.
// -----------------------------------------------------------------------------
module vpu_mem_resp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    vpu_mem_resp_if.slave      bus
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // True when the full-width address lands inside the stored range.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < DEPTH_U);
    endfunction

    state_t            state_r;
    state_t            state_n;
    logic              rdy_r;
    logic              ready_s;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              a_in_s;
    logic              b_in_s;
    logic              c_in_s;
    logic              h_in_s;
    logic [IDX_W-1:0]  idx_a_s;
    logic [IDX_W-1:0]  idx_b_s;
    logic [IDX_W-1:0]  idx_c_s;
    logic [IDX_W-1:0]  idx_h_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    logic              vpu_wr_s;
    logic              host_wr_s;
    logic              buf_commit_s;

    logic              buf_valid_r;
    logic              buf_valid_n;
    logic [IDX_W-1:0]  buf_addr_r;
    logic [IDX_W-1:0]  buf_addr_n;
    logic [DATA_W-1:0] buf_data_r;
    logic [DATA_W-1:0] buf_data_n;

    logic              err_r;
    logic              err_n;

    // Stage 0 captures the read at the sampling edge; the last stage drives
    // the outputs, so data appears RD_LAT-1 edges after sampling.
    logic [DATA_W-1:0] pipe_a_r [RD_LAT];
    logic [DATA_W-1:0] pipe_b_r [RD_LAT];

`ifdef VPU_MEM_ZERO_INIT_EN
    logic [IDX_W-1:0]  clr_cnt_r;
`endif

    assign ready_s = (state_r == ST_READY);

    // Next-state logic: CLEAR sweeps the memory (or passes straight through
    // when zero-init is not built), READY is terminal until reset.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_CLEAR: begin
`ifdef VPU_MEM_ZERO_INIT_EN
                if (clr_cnt_r == IDX_W'(DEPTH - 1)) begin
                    state_n = ST_READY;
                end else begin
                    state_n = ST_CLEAR;
                end
`else
                state_n = ST_READY;
`endif
            end
            ST_READY: state_n = ST_READY;
            default:  state_n = ST_CLEAR;
        endcase
    end

    // State register and the registered ready flag behind the three enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            rdy_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            rdy_r   <= (state_n == ST_READY);
        end
    end

`ifdef VPU_MEM_ZERO_INIT_EN
    // Clear counter: one address per cycle while in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_r <= '0;
        end else if (state_r == ST_CLEAR) begin
            clr_cnt_r <= clr_cnt_r + IDX_W'(1);
        end
    end
`endif

    // Address decode, combinational read of the pre-edge contents, write
    // arbitration, host buffer next value and sticky error update.
    always_comb begin
        a_in_s  = in_range(bus.addr_a);
        b_in_s  = in_range(bus.addr_b);
        c_in_s  = in_range(bus.addr_c);
        h_in_s  = in_range(bus.host_addr);
        idx_a_s = bus.addr_a[IDX_W-1:0];
        idx_b_s = bus.addr_b[IDX_W-1:0];
        idx_c_s = bus.addr_c[IDX_W-1:0];
        idx_h_s = bus.host_addr[IDX_W-1:0];

        rd_a_s = '0;
        if (a_in_s) begin
            rd_a_s = mem_r[idx_a_s];
        end else begin
            rd_a_s = '0;
        end

        rd_b_s = '0;
        if (b_in_s) begin
            rd_b_s = mem_r[idx_b_s];
        end else begin
            rd_b_s = '0;
        end

        vpu_wr_s     = ready_s && bus.done && c_in_s;
        host_wr_s    = ready_s && bus.host_we && !bus.done && h_in_s;
        buf_commit_s = ready_s && buf_valid_r && !bus.done;

        buf_valid_n = buf_valid_r;
        buf_addr_n  = buf_addr_r;
        buf_data_n  = buf_data_r;
        if (ready_s && bus.done && bus.host_we) begin
            // Newest colliding host write always replaces whatever is parked;
            // a host write aimed at the VPU target address is dropped.
            buf_valid_n = h_in_s && (bus.host_addr != bus.addr_c);
            buf_addr_n  = idx_h_s;
            buf_data_n  = bus.host_wdata;
        end else if (buf_commit_s) begin
            buf_valid_n = 1'b0;
        end else begin
            buf_valid_n = buf_valid_r;
        end

        err_n = err_r;
        if (ready_s && (!a_in_s || !b_in_s || (bus.done && !c_in_s))) begin
            err_n = 1'b1;
        end else begin
            err_n = err_r;
        end
    end

    // Memory array: zero sweep in CLEAR, then VPU, buffered-host and direct
    // host writes. The direct host write is placed last so that it overrides
    // an older buffered write to the same address in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
`ifdef VPU_MEM_ZERO_INIT_EN
            if (state_r == ST_CLEAR) begin
                mem_r[clr_cnt_r] <= '0;
            end
`endif
            if (vpu_wr_s) begin
                mem_r[idx_c_s] <= bus.data_c;
            end
            if (buf_commit_s) begin
                mem_r[buf_addr_r] <= buf_data_r;
            end
            if (host_wr_s) begin
                mem_r[idx_h_s] <= bus.host_wdata;
            end
        end
    end

    // Host buffer and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_r <= 1'b0;
            buf_addr_r  <= '0;
            buf_data_r  <= '0;
            err_r       <= 1'b0;
        end else begin
            buf_valid_r <= buf_valid_n;
            buf_addr_r  <= buf_addr_n;
            buf_data_r  <= buf_data_n;
            err_r       <= err_n;
        end
    end

    // Read pipeline. Stage 0 only loads while READY, so outputs hold during
    // CLEAR; once READY a read is issued every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_a_r[k] <= '0;
                pipe_b_r[k] <= '0;
            end
        end else begin
            if (ready_s) begin
                pipe_a_r[0] <= rd_a_s;
                pipe_b_r[0] <= rd_b_s;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_a_r[k] <= pipe_a_r[k-1];
                pipe_b_r[k] <= pipe_b_r[k-1];
            end
        end
    end

    assign bus.data_a       = pipe_a_r[RD_LAT-1];
    assign bus.data_b       = pipe_b_r[RD_LAT-1];
    assign bus.mem_rdy      = rdy_r;
    assign bus.mem_read_en  = rdy_r;
    assign bus.mem_write_en = rdy_r;
    assign bus.err          = err_r;

endmodule

// File: tb/tb_vpu_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_vpu_mem_resp
// Self-checking bench for vpu_mem_resp (DATA_W=32, ADDR_W=13, DEPTH=32,
// RD_LAT=2). A transaction-level model (array memory, read queue with due
// times, parked host write) predicts every output after each clock edge.
// Words whose content is unspecified (no zero-init) are tracked as unknown
// and their read data is not compared.
// -----------------------------------------------------------------------------
module tb_vpu_mem_resp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 32;
    localparam int RD_LAT = 2;
`ifdef VPU_MEM_ZERO_INIT_EN
    localparam bit ZI       = 1'b1;
    localparam int INIT_CYC = DEPTH;
`else
    localparam bit ZI       = 1'b0;
    localparam int INIT_CYC = 1;
`endif

    logic clk;
    logic rst;

    vpu_mem_resp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vpu_mem_resp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
        bit          ka;
        bit          kb;
    } rd_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;

    logic [31:0] mm [DEPTH];
    bit          mk [DEPTH];
    rd_t         q[$];
    bit          m_ready = 1'b0;
    int          m_cnt   = 0;
    bit          m_err   = 1'b0;
    bit          buf_v   = 1'b0;
    logic [4:0]  buf_a   = '0;
    logic [31:0] buf_d   = '0;
    logic [31:0] exp_a   = '0;
    logic [31:0] exp_b   = '0;
    bit          ka      = 1'b1;
    bit          kb      = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.done    = 1'b0;
        bus.host_we = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare every output shortly after the edge.
    task automatic step();
        rd_t        it;
        logic [4:0] ia;
        logic [4:0] ib;
        logic [4:0] ic;
        logic [4:0] ih;
        @(posedge clk);
        ia = bus.addr_a[4:0];
        ib = bus.addr_b[4:0];
        ic = bus.addr_c[4:0];
        ih = bus.host_addr[4:0];
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            q.delete();
            buf_v   = 1'b0;
            exp_a   = '0;
            exp_b   = '0;
            ka      = 1'b1;
            kb      = 1'b1;
            m_err   = 1'b0;
            if (!ZI) begin
                for (int i = 0; i < DEPTH; i++) mk[i] = 1'b0;
            end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt >= INIT_CYC) begin
                m_ready = 1'b1;
                if (ZI) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mm[i] = '0;
                        mk[i] = 1'b1;
                    end
                end
            end
        end else begin
            it.due = cyc + RD_LAT - 1;
            if (int'(bus.addr_a) < DEPTH) begin
                it.a  = mm[ia];
                it.ka = mk[ia];
            end else begin
                it.a  = '0;
                it.ka = 1'b1;
                m_err = 1'b1;
            end
            if (int'(bus.addr_b) < DEPTH) begin
                it.b  = mm[ib];
                it.kb = mk[ib];
            end else begin
                it.b  = '0;
                it.kb = 1'b1;
                m_err = 1'b1;
            end
            q.push_back(it);
            if (bus.done) begin
                if (int'(bus.addr_c) < DEPTH) begin
                    mm[ic] = bus.data_c;
                    mk[ic] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                if (bus.host_we) begin
                    buf_v = (bus.host_addr != bus.addr_c);
                    buf_a = ih;
                    buf_d = bus.host_wdata;
                end
            end else begin
                if (buf_v) begin
                    mm[buf_a] = buf_d;
                    mk[buf_a] = 1'b1;
                    buf_v     = 1'b0;
                end
                if (bus.host_we) begin
                    mm[ih] = bus.host_wdata;
                    mk[ih] = 1'b1;
                end
            end
        end
        while (q.size() > 0 && q[0].due <= cyc) begin
            it    = q.pop_front();
            exp_a = it.a;
            exp_b = it.b;
            ka    = it.ka;
            kb    = it.kb;
        end
        cyc++;
        #1;
        chk("mem_rdy", 32'(bus.mem_rdy), 32'(m_ready));
        chk("mem_read_en", 32'(bus.mem_read_en), 32'(m_ready));
        chk("mem_write_en", 32'(bus.mem_write_en), 32'(m_ready));
        chk("err", 32'(bus.err), 32'(m_err));
        if (ka) chk("data_a", bus.data_a, exp_a);
        if (kb) chk("data_b", bus.data_b, exp_b);
        @(negedge clk);
    endtask

    task automatic rand_inputs(input bit allow_oor);
        int hi;
        hi = allow_oor ? DEPTH + 9 : DEPTH - 1;
        bus.addr_a     = ADDR_W'($urandom_range(hi, 0));
        bus.addr_b     = ADDR_W'($urandom_range(hi, 0));
        bus.addr_c     = ADDR_W'($urandom_range(hi, 0));
        bus.data_c     = $urandom;
        bus.done       = ($urandom_range(2, 0) == 0);
        bus.host_we    = ($urandom_range(2, 0) == 0);
        bus.host_addr  = ADDR_W'($urandom_range(DEPTH - 1, 0));
        bus.host_wdata = $urandom;
        if ($urandom_range(3, 0) == 0) bus.host_addr = ADDR_W'(bus.addr_c[4:0]);
    endtask

    initial begin
        rst            = 1'b1;
        bus.addr_a     = '0;
        bus.addr_b     = '0;
        bus.addr_c     = '0;
        bus.data_c     = '0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = '0;
            mk[i] = 1'b0;
        end

        // Reset state, then initialisation timing of mem_rdy.
        step();
        step();
        rst = 1'b0;
        bus.addr_a = 13'd5;
        bus.addr_b = 13'd5;
        repeat (INIT_CYC + 1) step();
        step();
        step();
`ifdef VPU_MEM_ZERO_INIT_EN
        chk("zero_init_a5", bus.data_a, 32'h0000_0000);
`endif

        // Preload every address from the host port.
        for (int i = 0; i < DEPTH; i++) begin
            bus.host_we    = 1'b1;
            bus.host_addr  = ADDR_W'(i);
            bus.host_wdata = $urandom;
            bus.addr_a     = ADDR_W'($urandom_range(DEPTH - 1, 0));
            bus.addr_b     = ADDR_W'($urandom_range(DEPTH - 1, 0));
            step();
        end
        idle();

        // Preload then read with latency 2.
        bus.host_we    = 1'b1;
        bus.host_addr  = 13'd3;
        bus.host_wdata = 32'hDEAD_BEEF;
        step();
        idle();
        bus.addr_a = 13'd3;
        step();
        step();
        chk("preload_read3", bus.data_a, 32'hDEAD_BEEF);

        // VPU and host write collide; host write lands one cycle later.
        bus.done       = 1'b1;
        bus.addr_c     = 13'd4;
        bus.data_c     = 32'h0000_0011;
        bus.host_we    = 1'b1;
        bus.host_addr  = 13'd7;
        bus.host_wdata = 32'h0000_0022;
        bus.addr_a     = 13'd4;
        bus.addr_b     = 13'd7;
        step();
        idle();
        step();
        step();
        step();
        chk("collision_mem4", bus.data_a, 32'h0000_0011);
        chk("collision_mem7", bus.data_b, 32'h0000_0022);

        // Read-during-write returns old data, the next read the new data.
        bus.host_we    = 1'b1;
        bus.host_addr  = 13'd2;
        bus.host_wdata = 32'h0000_0005;
        step();
        idle();
        bus.done   = 1'b1;
        bus.addr_c = 13'd2;
        bus.data_c = 32'h0000_0009;
        bus.addr_a = 13'd2;
        step();
        idle();
        step();
        chk("rdw_old", bus.data_a, 32'h0000_0005);
        step();
        chk("rdw_new", bus.data_a, 32'h0000_0009);

        // Random in-range traffic: err must stay low.
        for (int n = 0; n < 200; n++) begin
            rand_inputs(1'b0);
            step();
        end
        idle();
        chk("err_clean", 32'(bus.err), 32'd0);

        // Out-of-range read on port B.
        bus.addr_a = 13'd1;
        bus.addr_b = 13'd40;
        step();
        bus.addr_b = 13'd1;
        step();
        repeat (4) step();
        chk("oor_err_sticky", 32'(bus.err), 32'd1);

        // Random traffic including out-of-range addresses.
        for (int n = 0; n < 200; n++) begin
            rand_inputs(1'b1);
            step();
        end
        idle();

        // Reset in the middle of initialisation, with stray strobes.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            rand_inputs(1'b1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_after_rst", 32'(bus.err), 32'd0);
        for (int n = 0; n < INIT_CYC + 20; n++) begin
            rand_inputs(1'b0);
            step();
        end
        idle();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vpu_mem_resp.md
VPU_MEM_RESP -- requirements
Module: vpu_mem_resp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the data word width.
REQ-002 SHALL have parameter ADDR_W, default 13, meaning the VPU address width.
REQ-003 SHALL have parameter DEPTH, default 32, meaning the number of stored words (addresses 0..DEPTH-1).
REQ-004 SHALL have parameter RD_LAT, default 2, range 1..3, meaning read latency in cycles.
REQ-005 SHALL have port clk, input, 1 bit, the clock; port rst, input, 1 bit, the reset, which is synchronous and active-high.
REQ-006 SHALL have port addr_a, input, ADDR_W bits, the operand A read address.
REQ-007 SHALL have port addr_b, input, ADDR_W bits, the operand B / constant read address.
REQ-008 SHALL have port addr_c, input, ADDR_W bits, the result write address.
REQ-009 SHALL have port data_c, input, DATA_W bits, the result write data.
REQ-010 SHALL have port done, input, 1 bit, a one-cycle write strobe for addr_c/data_c.
REQ-011 SHALL have port data_a, output, DATA_W bits, the read data for addr_a.
REQ-012 SHALL have port data_b, output, DATA_W bits, the read data for addr_b.
REQ-013 SHALL have port mem_rdy, output, 1 bit, meaning the memory is accepting VPU traffic.
REQ-014 SHALL have ports mem_read_en and mem_write_en, outputs, 1 bit each, meaning the read port and the write port are enabled.
REQ-015 SHALL have ports host_we (input, 1 bit), host_addr (input, ADDR_W bits) and host_wdata (input, DATA_W bits), forming the host preload write port.
REQ-016 SHALL have port err, output, 1 bit, a sticky out-of-range access flag.

Function
REQ-017 SHALL implement states CLEAR and READY; mem_rdy, mem_read_en and mem_write_en SHALL be high only in READY.
REQ-018 CLEAR SHALL write 0 to address 0, 1, ... DEPTH-1, one address per cycle, using a clear counter; after writing DEPTH-1 it SHALL go to READY on the next cycle, so mem_rdy rises exactly DEPTH cycles after reset release.
REQ-019 In READY, the address sampled at edge t SHALL appear on data_a/data_b at edge t+RD_LAT-1 (RD_LAT-stage pipeline); outputs SHALL hold between updates.
REQ-020 Reads SHALL be fully pipelined, accepting a new address every cycle.
REQ-021 A read of an address not less than DEPTH SHALL return 0 and set err.
REQ-022 done=1 in READY SHALL write data_c to mem[addr_c] at that edge; addr_c not less than DEPTH SHALL ignore the write and set err.
REQ-023 Read-during-write: a read sampled in the same cycle as a write to the same address SHALL return the old data.
REQ-024 host_we=1 with done=0 SHALL write host_wdata to mem[host_addr] in that cycle.
REQ-025 host_we and done in the same cycle: the VPU write SHALL win; the host write SHALL go to a one-entry buffer and commit on the next cycle without done. If the host write targets the same address as the VPU write, it SHALL be dropped.
REQ-026 A buffered host write pending while a new host_we arrives with done=1 SHALL cause the older buffered write to be discarded in favour of the newer one.
REQ-027 done or host_we during CLEAR SHALL be ignored; err SHALL NOT be set.
REQ-028 err SHALL be cleared only by rst.

Reset
REQ-029 rst SHALL be sampled on posedge clk and SHALL take priority over all activity.
REQ-030 On rst: state=CLEAR, clear counter=0, data_a=0, data_b=0, read pipeline=0, host buffer empty, err=0, and mem_rdy, mem_read_en and mem_write_en=0.
REQ-031 rst asserted mid-operation SHALL abort any in-flight reads and any buffered write, then restart CLEAR.

Configuration
REQ-032 With VPU_MEM_ZERO_INIT_EN defined, the block SHALL behave as REQ-018.
REQ-033 With VPU_MEM_ZERO_INIT_EN undefined, reset SHALL enter READY directly; mem_rdy SHALL be 1 on the first cycle after reset release; memory contents after reset SHALL be unspecified, and the clear counter SHALL not be built.

Verification
REQ-034 Zero-init (default, DEPTH=32): release rst -> mem_rdy=0 for 32 cycles, then 1; a read of address 5 -> data_a=0.
REQ-035 Preload then read (RD_LAT=2): host_we writes 0xDEADBEEF to address 3; addr_a=3 at edge t -> data_a=0xDEADBEEF at edge t+1.
REQ-036 Write collision: done with addr_c=4, data_c=0x11 and host_we with host_addr=7, host_wdata=0x22 in the same cycle -> mem[4]=0x11; mem[7]=0x22 one cycle later.
REQ-037 Out-of-range: addr_b=40 -> data_b=0 and err=1; err stays 1 until rst.
REQ-038 Read-during-write: mem[2]=0x5, then done writes 0x9 to address 2 while addr_a=2 -> that read returns 0x5; the next read returns 0x9.
REQ-039 Reset mid-clear: assert rst at clear counter 10 -> the counter restarts at 0, and mem_rdy rises 32 cycles after release.
